block_scheduler: RTL and testbench

Parametrised kernel block scheduler for the GPU top level. It splits a launch of `thread_count` threads into blocks of `THREADS_PER_BLOCK` and hands blocks to idle compute cores in round-robin order. It tracks completions and signals kernel done. It replaces the fixed two-core dispatcher: widths are configurable, cores are recycled as soon as they finish, a partial last block gets its true thread count, and launches can be aborted.

---
 rtl/block_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_block_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_scheduler.sv
// block_scheduler
// Splits a kernel launch into THREADS_PER_BLOCK-sized blocks and dispatches
// them one per cycle to idle compute cores in round-robin order. Cores are
// recycled as soon as they report done. The kernel completes once every block
// has finished and all cores are idle again. A running launch can be aborted.
module block_scheduler #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_W              = 8,
  parameter int BID_W             = 8,
  localparam int CTC_W            = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [TC_W-1:0]      thread_count,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NUM_CORES-1:0] core_reset,
  output logic [BID_W-1:0]     core_block_id [NUM_CORES],
  output logic [CTC_W-1:0]     core_thread_count [NUM_CORES],
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [BID_W:0]       blocks_done
);

  localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int TCX_W    = TC_W + 1;
  // Counters are wide enough for both the block-id range and the block total.
  localparam int CNT_W    = ((TC_W > BID_W) ? TC_W : BID_W) + 1;
  localparam int REM_W    = CNT_W + LOG2_TPB;
  localparam int PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CAND_W   = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} top_state_t;
  typedef enum logic [1:0] {C_IDLE, C_RST, C_RUN} core_state_t;

  top_state_t          state_reg;
  logic [TC_W-1:0]     tc_reg;
  logic [CNT_W-1:0]    total_blocks_reg;
  logic [CNT_W-1:0]    dispatched_reg;
  logic [CNT_W-1:0]    blocks_done_reg;
  logic [PTR_W-1:0]    rr_ptr_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                aborted_reg;

  logic [NUM_CORES-1:0] core_idle;
  logic [NUM_CORES-1:0] core_finish;
  logic [NUM_CORES-1:0] dispatch_onehot;
  logic [TCX_W-1:0]     total_calc;
  logic [REM_W-1:0]     remaining;
  logic [CTC_W-1:0]     next_ctc;
  logic [CNT_W-1:0]     finish_count;
  logic [CAND_W-1:0]    cand;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 dispatch;
  logic                 take_abort;
  logic                 all_idle;

  // Ceiling division evaluated one bit wider so a full-range count cannot wrap.
  assign total_calc = (TCX_W'(thread_count) + TCX_W'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB;

  // Threads left for the block about to be dispatched; only the last block can be partial.
  assign remaining = REM_W'(tc_reg) - (REM_W'(dispatched_reg) << LOG2_TPB);
  assign next_ctc  = (remaining >= REM_W'(THREADS_PER_BLOCK)) ? CTC_W'(THREADS_PER_BLOCK)
                                                              : remaining[CTC_W-1:0];

  assign take_abort = (state_reg == S_RUN) && abort;
  assign all_idle   = &core_idle;
  assign dispatch   = (state_reg == S_RUN) && !abort && pick_valid &&
                      (dispatched_reg < total_blocks_reg);

  // Round-robin search: first idle core at or after the pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = CAND_W'(rr_ptr_reg) + CAND_W'(i);
      if (cand >= CAND_W'(NUM_CORES)) cand = cand - CAND_W'(NUM_CORES);
      if (!pick_valid && core_idle[cand[PTR_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // One-hot select of the core receiving this cycle's block.
  always_comb begin
    dispatch_onehot = '0;
    if (dispatch) dispatch_onehot[pick_idx] = 1'b1;
  end

  // Several cores may complete in the same cycle; count them all.
  always_comb begin
    finish_count = '0;
    for (int i = 0; i < NUM_CORES; i++) finish_count = finish_count + CNT_W'(core_finish[i]);
  end

  // Launch-level FSM: latch the launch, track dispatch/completion, detect done and abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      tc_reg           <= '0;
      total_blocks_reg <= '0;
      dispatched_reg   <= '0;
      blocks_done_reg  <= '0;
      rr_ptr_reg       <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      aborted_reg      <= 1'b0;
    end else begin
      aborted_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            tc_reg           <= thread_count;
            total_blocks_reg <= CNT_W'(total_calc);
            dispatched_reg   <= '0;
            blocks_done_reg  <= '0;
            done_reg         <= 1'b0;
            busy_reg         <= 1'b1;
            state_reg        <= S_RUN;
          end
        end
        S_RUN: begin
          blocks_done_reg <= blocks_done_reg + finish_count;
          if (abort) begin
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end else if ((blocks_done_reg == total_blocks_reg) && all_idle) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else if (dispatch) begin
            dispatched_reg <= dispatched_reg + CNT_W'(1);
            rr_ptr_reg     <= (pick_idx == PTR_W'(NUM_CORES - 1)) ? '0 : pick_idx + PTR_W'(1);
          end
        end
        S_DONE: begin
          if (!start) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    core_state_t      cstate_reg;
    logic             run_reg;
    logic             rst_reg;
    logic [BID_W-1:0] bid_reg;
    logic [CTC_W-1:0] ctc_reg;

    // Per-core lifecycle: one-cycle reset pulse, then run until the core reports done.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cstate_reg <= C_IDLE;
        run_reg    <= 1'b0;
        rst_reg    <= 1'b0;
        bid_reg    <= '0;
        ctc_reg    <= '0;
      end else if (take_abort) begin
        cstate_reg <= C_IDLE;
        run_reg    <= 1'b0;
        rst_reg    <= 1'b1;
      end else begin
        rst_reg <= 1'b0;
        case (cstate_reg)
          C_IDLE: begin
            if (dispatch_onehot[gi]) begin
              cstate_reg <= C_RST;
              rst_reg    <= 1'b1;
              bid_reg    <= dispatched_reg[BID_W-1:0];
              ctc_reg    <= next_ctc;
            end
          end
          C_RST: begin
            cstate_reg <= C_RUN;
            run_reg    <= 1'b1;
          end
          C_RUN: begin
            if (core_done[gi]) begin
              cstate_reg <= C_IDLE;
              run_reg    <= 1'b0;
            end
          end
          default: cstate_reg <= C_IDLE;
        endcase
      end
    end

    assign core_idle[gi]         = (cstate_reg == C_IDLE);
    assign core_finish[gi]       = (cstate_reg == C_RUN) && core_done[gi];
    assign core_start[gi]        = run_reg;
    assign core_reset[gi]        = rst_reg;
    assign core_block_id[gi]     = bid_reg;
    assign core_thread_count[gi] = ctc_reg;
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign aborted     = aborted_reg;
  assign blocks_done = blocks_done_reg[BID_W:0];

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: a 2-core instance for most scenarios
// and a 4-core instance for simultaneous completions.
module tb_block_scheduler;
  logic       clk;
  logic       reset;

  logic       start, abort;
  logic [7:0] tc;
  logic [1:0] cdone;
  logic [1:0] cstart, creset;
  logic [7:0] bid [2];
  logic [2:0] ctc [2];
  logic       busy, done, aborted;
  logic [8:0] bdone;

  logic       start4, abort4;
  logic [7:0] tc4;
  logic [3:0] cdone4;
  logic [3:0] cstart4, creset4;
  logic [7:0] bid4 [4];
  logic [2:0] ctc4 [4];
  logic       busy4, done4, aborted4;
  logic [8:0] bdone4;

  int checks = 0;
  int errors = 0;

  block_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .thread_count(tc),
    .core_done(cdone), .core_start(cstart), .core_reset(creset),
    .core_block_id(bid), .core_thread_count(ctc), .busy(busy), .done(done),
    .aborted(aborted), .blocks_done(bdone)
  );

  block_scheduler #(.NUM_CORES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(abort4), .thread_count(tc4),
    .core_done(cdone4), .core_start(cstart4), .core_reset(creset4),
    .core_block_id(bid4), .core_thread_count(ctc4), .busy(busy4), .done(done4),
    .aborted(aborted4), .blocks_done(bdone4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 8 threads on 2 cores: two full blocks on consecutive cycles, both complete together.
  task automatic scenario_basic(input string p);
    start = 1'b1; tc = 8'd8;
    tick;
    check({p, "busy_e0"}, busy, 1);
    check({p, "creset_e0"}, creset, 0);
    start = 1'b0; tc = 8'd3;
    tick;
    check({p, "creset_e1"}, creset, 2'b01);
    check({p, "bid0_e1"}, bid[0], 0);
    check({p, "ctc0_e1"}, ctc[0], 4);
    check({p, "cstart_e1"}, cstart, 0);
    tick;
    check({p, "cstart_e2"}, cstart, 2'b01);
    check({p, "creset_e2"}, creset, 2'b10);
    check({p, "bid1_e2"}, bid[1], 1);
    check({p, "ctc1_e2"}, ctc[1], 4);
    tick;
    check({p, "cstart_e3"}, cstart, 2'b11);
    check({p, "creset_e3"}, creset, 0);
    cdone = 2'b11;
    tick;
    check({p, "cstart_ed"}, cstart, 0);
    check({p, "bdone_ed"}, bdone, 2);
    check({p, "done_ed"}, done, 0);
    cdone = 2'b00;
    tick;
    check({p, "done_ed1"}, done, 1);
    check({p, "busy_ed1"}, busy, 0);
    check({p, "bdone_ed1"}, bdone, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; tc = '0; cdone = '0;
    start4 = 1'b0; abort4 = 1'b0; tc4 = '0; cdone4 = '0;
    #2 reset = 1'b0;
    #20;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cstart", cstart, 0);
    check("rst_creset", creset, 0);
    check("rst_bid1", bid[1], 0);
    check("rst_ctc0", ctc[0], 0);
    check("rst_bdone", bdone, 0);
    check("rst_aborted", aborted, 0);
    check("rst_busy4", busy4, 0);
    reset = 1'b1;
    tick;

    // Scenario 1
    scenario_basic("s1_");
    tick;
    check("s1_done_hold_idle", done, 1);

    // Scenario 2: 10 threads -> 3 blocks, last block has 2 threads
    start = 1'b1; tc = 8'd10;
    tick;
    check("s2_busy_e0", busy, 1);
    check("s2_done_clr", done, 0);
    check("s2_bdone_clr", bdone, 0);
    start = 1'b0; tc = 8'd0;
    tick;
    check("s2_creset_e1", creset, 2'b01);
    check("s2_ctc0_e1", ctc[0], 4);
    tick;
    check("s2_cstart_e2", cstart, 2'b01);
    check("s2_creset_e2", creset, 2'b10);
    tick;
    check("s2_cstart_e3", cstart, 2'b11);
    cdone = 2'b10;
    tick;
    check("s2_cstart_e4", cstart, 2'b01);
    check("s2_bdone_e4", bdone, 1);
    check("s2_creset_e4", creset, 0);
    cdone = 2'b00;
    tick;
    check("s2_creset_e5", creset, 2'b10);
    check("s2_bid1_e5", bid[1], 2);
    check("s2_ctc1_e5", ctc[1], 2);
    check("s2_bid0_hold", bid[0], 0);
    tick;
    check("s2_cstart_e6", cstart, 2'b11);
    cdone = 2'b11;
    tick;
    check("s2_bdone_e7", bdone, 3);
    check("s2_cstart_e7", cstart, 0);
    check("s2_done_e7", done, 0);
    cdone = 2'b00;
    tick;
    check("s2_done_e8", done, 1);
    check("s2_busy_e8", busy, 0);
    tick;

    // Scenario 3: zero threads
    start = 1'b1; tc = 8'd0;
    tick;
    check("z_busy_e0", busy, 1);
    check("z_done_e0", done, 0);
    start = 1'b0;
    tick;
    check("z_done_e1", done, 1);
    check("z_busy_e1", busy, 0);
    check("z_creset", creset, 0);
    check("z_cstart", cstart, 0);
    check("z_bid1_hold", bid[1], 2);
    tick;

    // Scenario 4: abort with two blocks running, then relaunch
    start = 1'b1; tc = 8'd8;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    check("ab_cstart_pre", cstart, 2'b11);
    abort = 1'b1;
    tick;
    check("ab_aborted", aborted, 1);
    check("ab_creset", creset, 2'b11);
    check("ab_cstart", cstart, 0);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    abort = 1'b0;
    tick;
    check("ab_aborted_pulse", aborted, 0);
    check("ab_creset_pulse", creset, 0);
    check("ab_done_after", done, 0);
    start = 1'b1; tc = 8'd8;
    tick;
    check("rl_busy", busy, 1);
    check("rl_bdone", bdone, 0);
    start = 1'b0;
    tick;
    check("rl_creset", creset, 2'b01);
    check("rl_bid0", bid[0], 0);
    tick;
    check("rl_cstart", cstart, 2'b01);
    check("rl_bid1", bid[1], 1);

    // Scenario 5: asynchronous reset between edges
    #3 reset = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_cstart", cstart, 0);
    check("ar_creset", creset, 0);
    check("ar_bid1", bid[1], 0);
    check("ar_ctc1", ctc[1], 0);
    check("ar_bdone", bdone, 0);
    check("ar_done", done, 0);
    tick;
    reset = 1'b1;
    scenario_basic("ar_");

    // Scenario 6: 4 cores, 16 threads, simultaneous completion
    start4 = 1'b1; tc4 = 8'd16;
    tick;
    check("q_busy_e0", busy4, 1);
    start4 = 1'b0;
    tick;
    check("q_creset_e1", creset4, 4'b0001);
    tick;
    check("q_creset_e2", creset4, 4'b0010);
    check("q_cstart_e2", cstart4, 4'b0001);
    tick;
    check("q_creset_e3", creset4, 4'b0100);
    tick;
    check("q_creset_e4", creset4, 4'b1000);
    check("q_bid3", bid4[3], 3);
    check("q_ctc3", ctc4[3], 4);
    tick;
    check("q_cstart_e5", cstart4, 4'b1111);
    check("q_bdone_e5", bdone4, 0);
    cdone4 = 4'b1111;
    tick;
    check("q_bdone_e6", bdone4, 4);
    check("q_cstart_e6", cstart4, 0);
    check("q_done_e6", done4, 0);
    cdone4 = 4'b0000;
    tick;
    check("q_done_e7", done4, 1);
    check("q_busy_e7", busy4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
